// File: rtl/cmd_engine.sv
// Host command engine for the 8-bit CPU core.
// Decodes byte commands, forces buses, strobes clocks and runs the CPU.
module cmd_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int CW_W = 32,
  parameter int FLAG_W = 4,
  parameter logic [CW_W-1:0] CW_RESET = '0,
  parameter logic [7:0] ID_BYTE = 8'h56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [DATA_W-1:0] opcode_in,
  output logic [CW_W-1:0]   ctrl_word,
  output logic              ctrl_en,
  output logic              cpu_clk_en,
  output logic              cpu_iclk_en,
  output logic              cpu_rst,
  input  logic              brk,
  input  logic              hlt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NB_D = (DATA_W + 7) / 8;
  localparam int NB_A = (ADDR_W + 7) / 8;
  localparam int NB_C = (CW_W + 7) / 8;
  localparam int NB_F = (FLAG_W + 7) / 8;
  localparam int RB = max2(max2(NB_A, NB_D), max2(NB_F, 2));
  localparam int AB = max2(max2(NB_A, NB_D), max2(NB_C, 2));
  localparam int RW = 8 * RB;
  localparam int AW = 8 * AB;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARG   = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_PULSE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;

  logic [2:0]    state;
  logic [7:0]    cmd;
  logic [3:0]    arg_idx;
  logic [3:0]    arg_last;
  logic [AW-1:0] arg_sr;
  logic [AW-1:0] arg_now;
  logic [RW-1:0] tx_sr;
  logic [3:0]    tx_cnt;
  logic [1:0]    phase;
  logic          run_lim;
  logic [15:0]   steps;
  logic          abort_q;

  logic          fire;
  logic          exec;
  logic          abort_now;
  logic [7:0]    ecmd;
  logic [RW-1:0] resp_v;
  logic [3:0]    resp_n;
  logic          c_ab;
  logic          c_lim;
  logic [15:0]   c_n;
  logic          stop;
  logic [7:0]    code;

  function automatic logic [3:0] nb_of(input logic [7:0] c);
    case (c)
      "A":           nb_of = 4'(NB_A);
      "B":           nb_of = 4'(NB_D);
      "O", "M", "r": nb_of = 4'(NB_C);
      "S":           nb_of = 4'd2;
      default:       nb_of = 4'd0;
    endcase
  endfunction

  assign rx_ready = (state == S_IDLE) || (state == S_ARG)
                 || (state == S_RUN);
  assign fire = rx_valid & rx_ready;
  assign tx_data = tx_sr[7:0];
  assign abort_now = fire && (state == S_RUN)
                  && (rx_data == 8'h1B);

  always_comb begin
    ecmd = (state == S_ARG) ? cmd : rx_data;
    exec = fire && (((state == S_IDLE) && (nb_of(rx_data) == 4'd0))
        || ((state == S_ARG) && (arg_idx == arg_last)));
    arg_now = arg_sr;
    if (state == S_ARG) arg_now[{arg_idx, 3'b000} +: 8] = rx_data;
  end

  // Response value is sampled here, in the decode cycle.
  always_comb begin
    resp_v = '0;
    resp_n = 4'd0;
    case (ecmd)
      "I": begin resp_v = RW'(ID_BYTE);   resp_n = 4'd1; end
      "a": begin resp_v = RW'(addr_in);   resp_n = 4'(NB_A); end
      "b": begin resp_v = RW'(bus_in);    resp_n = 4'(NB_D); end
      "s": begin resp_v = RW'(flags_in);  resp_n = 4'(NB_F); end
      "r": begin resp_v = RW'(opcode_in); resp_n = 4'(NB_D); end
      "A", "B", "f", "O", "M", "N", 8'hFF,
      "c", "C", "T", "Z", "R", "S": resp_n = 4'd0;
      default: begin resp_v = RW'(8'h3F); resp_n = 4'd1; end
    endcase
  end

  // Tick-boundary stop check, shared by run entry and the run loop.
  always_comb begin
    if (state == S_RUN) begin
      c_ab  = abort_q | abort_now;
      c_lim = run_lim;
      c_n   = steps;
    end else begin
      c_ab  = 1'b0;
      c_lim = (ecmd == "S");
      c_n   = arg_now[15:0];
    end
    stop = 1'b1;
    code = 8'h00;
    if (c_ab)                      code = "A";
    else if (brk)                  code = "B";
    else if (hlt)                  code = "H";
    else if (c_lim && c_n == 16'd0) code = "S";
    else                           stop = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd         <= 8'h00;
      arg_idx     <= 4'd0;
      arg_last    <= 4'd0;
      arg_sr      <= '0;
      tx_sr       <= '0;
      tx_cnt      <= 4'd0;
      tx_valid    <= 1'b0;
      phase       <= 2'd0;
      run_lim     <= 1'b0;
      steps       <= 16'd0;
      abort_q     <= 1'b0;
      bus_out     <= '0;
      bus_oe      <= 1'b0;
      addr_out    <= '0;
      addr_oe     <= 1'b0;
      ctrl_word   <= CW_RESET;
      ctrl_en     <= 1'b1;
      cpu_clk_en  <= 1'b0;
      cpu_iclk_en <= 1'b0;
      cpu_rst     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ARG: begin
          if (exec) begin
            state <= S_IDLE;
            if (resp_n != 4'd0) begin
              tx_sr    <= resp_v;
              tx_cnt   <= resp_n;
              tx_valid <= 1'b1;
              state    <= S_SEND;
            end
            case (ecmd)
              "A": begin
                addr_out <= arg_now[ADDR_W-1:0];
                addr_oe  <= 1'b1;
              end
              "B": begin
                bus_out <= arg_now[DATA_W-1:0];
                bus_oe  <= 1'b1;
              end
              "f": begin
                bus_oe  <= 1'b0;
                addr_oe <= 1'b0;
              end
              "O": begin
                bus_oe    <= 1'b0;
                addr_oe   <= 1'b0;
                ctrl_word <= arg_now[CW_W-1:0];
              end
              "M": ctrl_word <= arg_now[CW_W-1:0];
              "c": begin
                cpu_clk_en <= 1'b1;
                phase      <= 2'd3;
                state      <= S_PULSE;
              end
              "C": begin
                cpu_iclk_en <= 1'b1;
                phase       <= 2'd3;
                state       <= S_PULSE;
              end
              "Z": begin
                cpu_rst <= 1'b1;
                phase   <= 2'd3;
                state   <= S_PULSE;
              end
              "T": begin
                cpu_clk_en <= 1'b1;
                phase      <= 2'd1;
                state      <= S_PULSE;
              end
              "R", "S": begin
                run_lim <= c_lim;
                abort_q <= 1'b0;
                if (stop) begin
                  tx_sr    <= RW'({code, 8'h23});
                  tx_cnt   <= 4'd2;
                  tx_valid <= 1'b1;
                  state    <= S_SEND;
                end else begin
                  steps      <= c_lim ? c_n - 16'd1 : c_n;
                  ctrl_en    <= 1'b0;
                  cpu_clk_en <= 1'b1;
                  phase      <= 2'd1;
                  state      <= S_RUN;
                end
              end
              default: ;
            endcase
          end else if (fire && state == S_IDLE) begin
            cmd      <= rx_data;
            arg_idx  <= 4'd0;
            arg_last <= nb_of(rx_data) - 4'd1;
            arg_sr   <= '0;
            state    <= S_ARG;
          end else if (fire) begin
            arg_sr  <= arg_now;
            arg_idx <= arg_idx + 4'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_sr  <= tx_sr >> 8;
            tx_cnt <= tx_cnt - 4'd1;
            if (tx_cnt == 4'd1) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_PULSE, S_RUN: begin
          if (abort_now) abort_q <= 1'b1;
          case (phase)
            2'd1: begin
              cpu_clk_en <= 1'b0;
              phase      <= 2'd2;
            end
            2'd2: begin
              cpu_iclk_en <= 1'b1;
              phase       <= 2'd3;
            end
            2'd3: begin
              cpu_clk_en  <= 1'b0;
              cpu_iclk_en <= 1'b0;
              cpu_rst     <= 1'b0;
              phase       <= 2'd0;
              if (state == S_PULSE) state <= S_IDLE;
            end
            default: begin
              // Gap cycle between ticks keeps strobes non-adjacent.
              if (stop) begin
                tx_sr    <= RW'({code, 8'h23});
                tx_cnt   <= 4'd2;
                tx_valid <= 1'b1;
                ctrl_en  <= 1'b1;
                state    <= S_SEND;
              end else begin
                cpu_clk_en <= 1'b1;
                phase      <= 2'd1;
                if (run_lim) steps <= steps - 16'd1;
              end
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_engine.sv
// Randomized self-checking bench for cmd_engine.
// Drives the byte channel and checks responses, buses and strobes.
module tb_cmd_engine;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int CW_W = 32;
  localparam int FLAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic [DATA_W-1:0] bus_out;
  logic bus_oe;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [ADDR_W-1:0] addr_out;
  logic addr_oe;
  logic [FLAG_W-1:0] flags_in = '0;
  logic [DATA_W-1:0] opcode_in = '0;
  logic [CW_W-1:0] ctrl_word;
  logic ctrl_en;
  logic cpu_clk_en;
  logic cpu_iclk_en;
  logic cpu_rst;
  logic brk = 1'b0;
  logic hlt = 1'b0;

  cmd_engine dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .addr_in(addr_in), .addr_out(addr_out), .addr_oe(addr_oe),
    .flags_in(flags_in), .opcode_in(opcode_in),
    .ctrl_word(ctrl_word), .ctrl_en(ctrl_en),
    .cpu_clk_en(cpu_clk_en), .cpu_iclk_en(cpu_iclk_en),
    .cpu_rst(cpu_rst), .brk(brk), .hlt(hlt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int clk_cnt = 0;
  int iclk_cnt = 0;
  int rst_cnt = 0;
  int clk_cyc = 0;
  int iclk_cyc = 0;
  int rstb_cyc = 0;
  int bad_ce = 0;
  logic prev_any = 1'b0;
  logic run_watch = 1'b0;

  // Strobe monitor: counts pulses and checks their shape
  always @(negedge clk) begin
    cyc++;
    if (cpu_clk_en) begin clk_cnt++; clk_cyc = cyc; end
    if (cpu_iclk_en) begin iclk_cnt++; iclk_cyc = cyc; end
    if (cpu_rst) begin rst_cnt++; rstb_cyc = cyc; end
    if (cpu_clk_en | cpu_iclk_en | cpu_rst) begin
      checks++;
      if (prev_any || (cpu_clk_en && cpu_iclk_en)) begin
        fails++;
        $display("FAIL strobe_shape cyc=%0d got clk=%b iclk=%b prev=%b want single isolated",
                 cyc, cpu_clk_en, cpu_iclk_en, prev_any);
      end
      if (run_watch && ctrl_en) bad_ce++;
    end
    prev_any = cpu_clk_en | cpu_iclk_en | cpu_rst;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      checks++; fails++;
      $display("FAIL rx_accept got ready=0 want 1 byte=%h", b);
    end
    @(posedge clk);
    acc_cyc = cyc;
    #1 rx_valid = 1'b0;
  endtask

  task automatic get_byte(output logic [7:0] b, output logic stable,
                          input int hold);
    int n = 0;
    stable = 1'b1;
    b = 8'hxx;
    @(negedge clk);
    while (!tx_valid && n < 200) begin @(negedge clk); n++; end
    if (!tx_valid) begin
      checks++; fails++;
      $display("FAIL tx_timeout got tx_valid=0 want 1");
      return;
    end
    b = tx_data;
    repeat (hold) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== b) stable = 1'b0;
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  task automatic wait_cnt(input int base, input int want, input logic iclk);
    int n = 0;
    while (((iclk ? iclk_cnt : clk_cnt) - base) < want && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; fails++;
      $display("FAIL strobe_wait got timeout want %0d strobes", want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_hs got rdy=%b tv=%b td=%h want 1 0 00",
               rx_ready, tx_valid, tx_data);
    end
    checks++;
    if (bus_oe !== 1'b0 || addr_oe !== 1'b0 || bus_out !== 8'h00
        || addr_out !== 16'h0000) begin
      fails++;
      $display("FAIL reset_bus got boe=%b aoe=%b bo=%h ao=%h want 0 0 00 0000",
               bus_oe, addr_oe, bus_out, addr_out);
    end
    checks++;
    if (ctrl_word !== 32'h0 || ctrl_en !== 1'b1
        || {cpu_clk_en, cpu_iclk_en, cpu_rst} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl got cw=%h ce=%b str=%b%b%b want 0 1 000",
               ctrl_word, ctrl_en, cpu_clk_en, cpu_iclk_en, cpu_rst);
    end
  endtask

  task automatic test_id();
    logic [7:0] b;
    logic st;
    send_byte("I");
    get_byte(b, st, 0);
    checks++;
    if (b !== 8'h56) begin
      fails++; $display("FAIL id got %h want 56", b);
    end
    send_byte("x");
    get_byte(b, st, 1);
    checks++;
    if (b !== 8'h3F) begin
      fails++; $display("FAIL unknown got %h want 3f", b);
    end
    @(negedge clk);
    checks++;
    if (bus_oe !== 1'b0 || addr_oe !== 1'b0 || ctrl_en !== 1'b1
        || ctrl_word !== 32'h0 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL id_state got boe=%b aoe=%b ce=%b cw=%h tv=%b want 0 0 1 0 0",
               bus_oe, addr_oe, ctrl_en, ctrl_word, tx_valid);
    end
  endtask

  task automatic test_addr();
    logic [7:0] b0, b1;
    logic st;
    send_byte("A"); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    checks++;
    if (addr_out !== 16'h1234 || addr_oe !== 1'b1 || bus_oe !== 1'b0) begin
      fails++;
      $display("FAIL addr_force got ao=%h aoe=%b boe=%b want 1234 1 0",
               addr_out, addr_oe, bus_oe);
    end
    addr_in = 16'hBEEF;
    send_byte("a");
    addr_in = 16'h0000;
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    checks++;
    if (b0 !== 8'hEF || b1 !== 8'hBE) begin
      fails++; $display("FAIL addr_read got %h %h want ef be", b0, b1);
    end
    send_byte("f");
    @(negedge clk);
    checks++;
    if (addr_oe !== 1'b0 || bus_oe !== 1'b0 || addr_out !== 16'h1234) begin
      fails++;
      $display("FAIL float got aoe=%b boe=%b ao=%h want 0 0 1234",
               addr_oe, bus_oe, addr_out);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    logic st;
    int extra = 0;
    send_byte("M"); send_byte(8'h78); send_byte(8'h56);
    send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    checks++;
    if (ctrl_word !== 32'h12345678 || ctrl_en !== 1'b1) begin
      fails++;
      $display("FAIL ctrl_load got %h ce=%b want 12345678 1", ctrl_word, ctrl_en);
    end
    bus_in = 8'hA5;
    send_byte("b");
    bus_in = 8'h5A;
    get_byte(b, st, 5);
    checks++;
    if (b !== 8'hA5 || st !== 1'b1) begin
      fails++; $display("FAIL bus_hold got %h stable=%b want a5 1", b, st);
    end
    repeat (6) begin
      @(negedge clk);
      if (tx_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++; $display("FAIL bus_once got %0d extra cycles want 0", extra);
    end
  endtask

  task automatic test_pulses();
    int c0, i0, r0, a;
    c0 = clk_cnt; i0 = iclk_cnt;
    send_byte("T");
    a = acc_cyc;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (clk_cnt - c0 != 1 || iclk_cnt - i0 != 1
        || clk_cyc != a + 1 || iclk_cyc != a + 3) begin
      fails++;
      $display("FAIL tick got n=%0d/%0d at +%0d/+%0d want 1/1 at +1/+3",
               clk_cnt - c0, iclk_cnt - i0, clk_cyc - a, iclk_cyc - a);
    end
    c0 = clk_cnt; i0 = iclk_cnt; r0 = rst_cnt;
    send_byte("c"); send_byte("c");
    a = acc_cyc;
    send_byte("C");
    send_byte("Z");
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (clk_cnt - c0 != 2 || iclk_cnt - i0 != 1 || rst_cnt - r0 != 1
        || clk_cyc != a + 1) begin
      fails++;
      $display("FAIL pulses got clk=%0d iclk=%0d rst=%0d lat=%0d want 2 1 1 1",
               clk_cnt - c0, iclk_cnt - i0, rst_cnt - r0, clk_cyc - a);
    end
  endtask

  task automatic test_step();
    logic [7:0] b0, b1;
    logic st;
    int c0, i0;
    c0 = clk_cnt; i0 = iclk_cnt; bad_ce = 0;
    run_watch = 1'b1;
    send_byte("S"); send_byte(8'h05); send_byte(8'h00);
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    run_watch = 1'b0;
    checks++;
    if (b0 !== 8'h23 || b1 !== "S" || clk_cnt - c0 != 5
        || iclk_cnt - i0 != 5 || bad_ce != 0 || ctrl_en !== 1'b1) begin
      fails++;
      $display("FAIL step5 got %h %h clk=%0d iclk=%0d bad_ce=%0d ce=%b want 23 53 5 5 0 1",
               b0, b1, clk_cnt - c0, iclk_cnt - i0, bad_ce, ctrl_en);
    end
    c0 = clk_cnt;
    send_byte("S"); send_byte(8'h00); send_byte(8'h00);
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    checks++;
    if (b0 !== 8'h23 || b1 !== "S" || clk_cnt != c0) begin
      fails++;
      $display("FAIL step0 got %h %h ticks=%0d want 23 53 0", b0, b1, clk_cnt - c0);
    end
  endtask

  task automatic test_break();
    logic [7:0] b0, b1;
    logic st;
    int c0, i0;
    c0 = clk_cnt; i0 = iclk_cnt;
    send_byte("R");
    wait_cnt(i0, 3, 1'b1);
    brk = 1'b1;
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    brk = 1'b0;
    checks++;
    if (b0 !== 8'h23 || b1 !== "B" || clk_cnt - c0 != 3) begin
      fails++;
      $display("FAIL brk_run got %h %h ticks=%0d want 23 42 3", b0, b1, clk_cnt - c0);
    end
    hlt = 1'b1;
    c0 = clk_cnt;
    send_byte("R");
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    checks++;
    if (b0 !== 8'h23 || b1 !== "H" || clk_cnt != c0) begin
      fails++;
      $display("FAIL hlt_entry got %h %h ticks=%0d want 23 48 0", b0, b1, clk_cnt - c0);
    end
    brk = 1'b1;
    send_byte("S"); send_byte(8'h03); send_byte(8'h00);
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    brk = 1'b0; hlt = 1'b0;
    checks++;
    if (b1 !== "B" || clk_cnt != c0) begin
      fails++;
      $display("FAIL brk_prio got %h ticks=%0d want 42 0", b1, clk_cnt - c0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b0, b1;
    logic st;
    int c0, i0;
    c0 = clk_cnt; i0 = iclk_cnt;
    send_byte("R");
    wait_cnt(c0, 1, 1'b0);
    send_byte("x");
    send_byte(8'h1B);
    get_byte(b0, st, 0);
    get_byte(b1, st, 0);
    checks++;
    if (b0 !== 8'h23 || b1 !== "A" || clk_cnt - c0 != 1
        || iclk_cnt - i0 != 1) begin
      fails++;
      $display("FAIL abort got %h %h clk=%0d iclk=%0d want 23 41 1 1",
               b0, b1, clk_cnt - c0, iclk_cnt - i0);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] b;
    logic st;
    int i0, stray = 0;
    send_byte("B"); send_byte(8'hC3);
    i0 = iclk_cnt;
    send_byte("R");
    wait_cnt(i0, 1, 1'b1);
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_iclk_en !== 1'b0 || ctrl_en !== 1'b1 || tx_valid !== 1'b0
        || rx_ready !== 1'b1 || ctrl_word !== 32'h0) begin
      fails++;
      $display("FAIL rst_run got iclk=%b ce=%b tv=%b rdy=%b cw=%h want 0 1 0 1 0",
               cpu_iclk_en, ctrl_en, tx_valid, rx_ready, ctrl_word);
    end
    checks++;
    if (bus_oe !== 1'b0 || bus_out !== 8'h00 || addr_out !== 16'h0) begin
      fails++;
      $display("FAIL rst_bus got boe=%b bo=%h ao=%h want 0 00 0000",
               bus_oe, bus_out, addr_out);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid || cpu_clk_en || cpu_iclk_en) stray++;
    end
    checks++;
    if (stray != 0) begin
      fails++; $display("FAIL rst_quiet got %0d active cycles want 0", stray);
    end
    send_byte("I");
    get_byte(b, st, 0);
    checks++;
    if (b !== 8'h56) begin
      fails++; $display("FAIL rst_recover got %h want 56", b);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds [12];
    logic [7:0] unk [5];
    logic [15:0] m_addr;
    logic [7:0] m_bus;
    logic [31:0] m_cw;
    logic m_aoe, m_boe;
    cmds = '{"I", "a", "b", "s", "f", "N", 8'hFF, "A", "B", "O", "M", "r"};
    unk = '{8'h00, "x", "q", 8'h7E, 8'h1B};
    m_addr = 16'h0; m_bus = 8'h0; m_cw = 32'h0;
    m_aoe = 1'b0; m_boe = 1'b0;
    for (int it = 0; it < 60; it++) begin
      logic [7:0] c, got;
      logic [31:0] arg;
      logic [7:0] eq [$];
      logic st;
      int nb, sel;
      sel = $urandom_range(0, 16);
      c = (sel < 12) ? cmds[sel] : unk[sel - 12];
      case (c)
        "A": nb = 2;
        "B": nb = 1;
        "O", "M", "r": nb = 4;
        default: nb = 0;
      endcase
      arg = $urandom;
      addr_in = 16'($urandom);
      bus_in = 8'($urandom);
      flags_in = 4'($urandom);
      opcode_in = 8'($urandom);
      eq.delete();
      case (c)
        "I": eq.push_back(8'h56);
        "a": begin eq.push_back(addr_in[7:0]); eq.push_back(addr_in[15:8]); end
        "b": eq.push_back(bus_in);
        "s": eq.push_back({4'h0, flags_in});
        "r": eq.push_back(opcode_in);
        "f", "N", 8'hFF, "A", "B", "O", "M": ;
        default: eq.push_back(8'h3F);
      endcase
      send_byte(c);
      for (int k = 0; k < nb; k++) send_byte(8'(arg >> (8 * k)));
      addr_in = ~addr_in; bus_in = ~bus_in;
      flags_in = ~flags_in; opcode_in = ~opcode_in;
      case (c)
        "A": begin m_addr = arg[15:0]; m_aoe = 1'b1; end
        "B": begin m_bus = arg[7:0]; m_boe = 1'b1; end
        "f": begin m_aoe = 1'b0; m_boe = 1'b0; end
        "O": begin m_aoe = 1'b0; m_boe = 1'b0; m_cw = arg; end
        "M": m_cw = arg;
        default: ;
      endcase
      foreach (eq[k]) begin
        get_byte(got, st, $urandom_range(0, 2));
        checks++;
        if (got !== eq[k] || st !== 1'b1) begin
          fails++;
          $display("FAIL rand_resp it=%0d cmd=%h got %h stable=%b want %h",
                   it, c, got, st, eq[k]);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || addr_out !== m_addr || addr_oe !== m_aoe
          || bus_out !== m_bus || bus_oe !== m_boe || ctrl_word !== m_cw) begin
        fails++;
        $display("FAIL rand_state it=%0d cmd=%h got tv=%b a=%h/%b d=%h/%b cw=%h want 0 %h/%b %h/%b %h",
                 it, c, tx_valid, addr_out, addr_oe, bus_out, bus_oe, ctrl_word,
                 m_addr, m_aoe, m_bus, m_boe, m_cw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id();
    test_addr();
    test_backpressure();
    test_pulses();
    test_step();
    test_break();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cmd_engine.md
Name: cmd_engine

Overview:
- Synthesisable byte-stream command engine that lets a host drive and observe the 8-bit CPU core over a UART-style byte channel.
- Decodes single-byte commands with little-endian arguments. Forces the main and address buses, loads the control word, and issues clock-enable pulses.
- Runs the CPU until break, halt, step-limit or host abort.
- Parametrised in bus, address, control-word and flag widths, with bounded step-run and abort modes.

Parameters:
DATA_W, 8, main bus and opcode width
ADDR_W, 16, address bus width
CW_W, 32, control word width
FLAG_W, 4, flags width
CW_RESET, 0, control word value after reset
ID_BYTE, 8'h56, byte returned by 'I'

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  command/argument byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  engine accepts rx byte (transfer when valid&ready)
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts tx byte
bus_in  in  DATA_W  main bus observe
bus_out  out  DATA_W  main bus drive value
bus_oe  out  1  drive main bus
addr_in  in  ADDR_W  address bus observe
addr_out  out  ADDR_W  address bus drive value
addr_oe  out  1  drive address bus
flags_in  in  FLAG_W  CPU flags
opcode_in  in  DATA_W  current instruction register
ctrl_word  out  CW_W  host control word
ctrl_en  out  1  ctrl_word drives CPU (0 while running)
cpu_clk_en  out  1  one-cycle CPU clock strobe
cpu_iclk_en  out  1  one-cycle CPU inverted-clock strobe
cpu_rst  out  1  one-cycle CPU reset strobe
brk  in  1  CPU break, active-high
hlt  in  1  CPU halted, active-high

Behaviour:
- Reset values:
  - rx_ready=1, tx_valid=0, tx_data=0.
  - bus_oe=0, addr_oe=0, bus_out=0, addr_out=0.
  - ctrl_word=CW_RESET, ctrl_en=1.
  - All strobes 0. State IDLE.
- Reset mid-operation aborts any argument collection, transmission or run immediately. No partial response bytes follow.
- Byte widths: NB(W)=ceil(W/8).
  - Arguments arrive least-significant byte first. Bits beyond W in the last byte are ignored.
  - Responses are zero-extended to NB(W) bytes, sent LSB first.
- Response capture: the value is sampled into a shift register in the cycle the command is decoded. Later input changes do not alter it.
- tx handshake: tx_data is stable while tx_valid=1 and tx_ready=0. A byte completes on tx_valid&tx_ready. rx_ready=0 while SEND or a pulse sequence is active.
- States:
  - IDLE: rx_ready=1; a command byte is decoded on accept.
  - ARG: collect NB bytes.
  - EXEC: commit.
  - SEND: serialise response.
  - PULSE: clk/iclk/tick sequences.
  - RUN: autonomous run.
- Commands:
  - 'I': send ID_BYTE.
  - 'A' arg ADDR_W: addr_out<=arg, addr_oe<=1.
  - 'a': send addr_in.
  - 'B' arg DATA_W: bus_out<=arg, bus_oe<=1.
  - 'b': send bus_in.
  - 's': send flags_in.
  - 'f': bus_oe<=0, addr_oe<=0.
  - 'O' arg CW_W: both oe<=0 and ctrl_word<=arg, committed in the same cycle.
  - 'M' arg CW_W: ctrl_word<=arg.
  - 'N' or 8'hFF: no-op.
  - 'c': cpu_clk_en high for 1 cycle.
  - 'C': cpu_iclk_en high for 1 cycle.
  - 'T' (tick): cpu_clk_en at cycle 1, cycle 2 idle, cpu_iclk_en at cycle 3.
  - 'r' arg CW_W: the argument is discarded; send opcode_in.
  - 'Z': cpu_rst high for 1 cycle.
  - 'R': run unbounded.
  - 'S' arg 16 bits: run at most N ticks.
  - Any other byte: send '?' (8'h3F).
- Strobes are never high in two consecutive cycles. cpu_clk_en and cpu_iclk_en are never high together.
- Command latency: the first tx byte or strobe is asserted in the cycle after the final byte is accepted.
- RUN:
  - ctrl_en=0 for the whole run; it returns to 1 in the cycle the end marker is loaded.
  - Before each tick, check in priority order:
    - abort seen: marker "#A"
    - brk: marker "#B"
    - hlt: marker "#H"
    - step count exhausted ('S' only): marker "#S"
  - Otherwise perform one tick (3 cycles) and decrement the count.
  - 'S' with N=0 emits "#S" with zero ticks. The step counter does not wrap.
  - rx_ready=1 during RUN. 8'h1B latches an abort. Every other byte is accepted and discarded.
  - Abort takes effect at the next tick boundary; an in-progress tick completes.
  - If brk/hlt is already high at entry, the marker is emitted with zero ticks.
- The bus and address forcing and ctrl_word persist across commands and runs until changed.

Test Plan:
- Release reset, send 'I' -> tx 8'h56; send 'x' -> tx 8'h3F; all oe=0, ctrl_en=1, ctrl_word=CW_RESET.
- Send 'A',34,12 -> addr_out=16'h1234 with addr_oe=1; then 'a' with addr_in=16'hBEEF -> tx EF,EF... corrected: tx EF then BE; send 'f' -> both oe=0.
- Send 'M',78,56,34,12 -> ctrl_word=32'h12345678; hold tx_ready=0 for 5 cycles during 'b' with bus_in=8'hA5 -> tx_data stays A5, exactly one byte delivered.
- Send 'T' -> cpu_clk_en pulses at cycle t, cpu_iclk_en at t+2, each exactly 1 cycle wide.
- Send 'S',05,00 with brk=hlt=0 -> exactly 5 clk and 5 iclk strobes, ctrl_en=0 throughout, then tx '#','S'. Send 'R' with brk rising after 3 ticks -> tx "#B" after exactly 3 ticks.
- Send 'R' then 8'h1B mid-tick -> the current tick completes, then tx "#A"; assert rst low mid-run -> tx_valid=0 and all outputs at reset values immediately.
